// File: rtl/read_addr_seq.sv
// Read-address sequencer: walks a programmable [base, last] window by a fixed step,
// either wrapping continuously or stopping after one pass, with valid/ready handshake.
module read_addr_seq #(
    parameter int ADDR_W = 7,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_mode,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [ADDR_W-1:0] i_last_addr,
    input  logic [STEP_W-1:0] i_step,
    input  logic              i_addr_ready,
    output logic [ADDR_W-1:0] o_read_addr,
    output logic              o_addr_valid,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_wrap_pulse
);

    localparam int SUM_W = ADDR_W + 1;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t              r_state, w_state;
    logic [ADDR_W-1:0]   r_base, w_base;
    logic [ADDR_W-1:0]   r_last, w_last;
    logic [STEP_W-1:0]   r_step, w_step;
    logic                r_mode, w_mode;
    logic [ADDR_W-1:0]   r_addr, w_addr;
    logic                r_valid, w_valid;
    logic                r_busy, w_busy;
    logic                r_done, w_done;
    logic                r_wrap, w_wrap;
    logic [SUM_W-1:0]    w_sum;
    logic                w_bound;

    // Extra carry bit lets an overflowing step count as a boundary rather than aliasing low.
    assign w_sum   = {1'b0, r_addr} + SUM_W'(r_step);
    assign w_bound = w_sum[ADDR_W] | (w_sum[ADDR_W-1:0] > r_last);

    always_comb begin
        w_state = r_state;
        w_base  = r_base;
        w_last  = r_last;
        w_step  = r_step;
        w_mode  = r_mode;
        w_addr  = r_addr;
        w_valid = r_valid;
        w_busy  = r_busy;
        w_done  = 1'b0;
        w_wrap  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start && !i_stop) begin
                    w_state = S_RUN;
                    w_base  = i_base_addr;
                    w_last  = i_last_addr;
                    w_step  = (i_step == '0) ? STEP_W'(1) : i_step;
                    w_mode  = i_mode;
                    w_addr  = i_base_addr;
                    w_valid = 1'b1;
                    w_busy  = 1'b1;
                end
            end
            S_RUN: begin
                if (i_stop) begin
                    w_state = S_IDLE;
                    w_addr  = '0;
                    w_valid = 1'b0;
                    w_busy  = 1'b0;
                end else if (r_valid && i_addr_ready) begin
                    if (!w_bound) begin
                        w_addr = w_sum[ADDR_W-1:0];
                    end else if (!r_mode) begin
                        w_addr = r_base;
                        w_wrap = 1'b1;
                    end else begin
                        w_state = S_IDLE;
                        w_addr  = '0;
                        w_valid = 1'b0;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                    end
                end
            end
            default: begin
                w_state = S_IDLE;
                w_addr  = '0;
                w_valid = 1'b0;
                w_busy  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_base  <= '0;
            r_last  <= '0;
            r_step  <= '0;
            r_mode  <= 1'b0;
            r_addr  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_base  <= w_base;
            r_last  <= w_last;
            r_step  <= w_step;
            r_mode  <= w_mode;
            r_addr  <= w_addr;
            r_valid <= w_valid;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_wrap  <= w_wrap;
        end
    end

    assign o_read_addr  = r_addr;
    assign o_addr_valid = r_valid;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_wrap_pulse = r_wrap;

endmodule

// File: tb/tb_read_addr_seq.sv
// Bench for read_addr_seq: table of window configurations with expected address
// streams fed through a scoreboard queue, plus hand sequences for stall/stop/reset.
module tb_read_addr_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic       i_stop = 1'b0;
    logic       i_mode = 1'b0;
    logic [6:0] i_base_addr = '0;
    logic [6:0] i_last_addr = '0;
    logic [3:0] i_step = '0;
    logic       i_addr_ready = 1'b1;
    logic [6:0] o_read_addr;
    logic       o_addr_valid;
    logic       o_busy;
    logic       o_done;
    logic       o_wrap_pulse;

    read_addr_seq #(.ADDR_W(7), .STEP_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_stop(i_stop), .i_mode(i_mode),
        .i_base_addr(i_base_addr), .i_last_addr(i_last_addr), .i_step(i_step),
        .i_addr_ready(i_addr_ready), .o_read_addr(o_read_addr), .o_addr_valid(o_addr_valid),
        .o_busy(o_busy), .o_done(o_done), .o_wrap_pulse(o_wrap_pulse)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic           mode;
        logic [6:0]     base;
        logic [6:0]     last;
        logic [3:0]     step;
        logic [3:0]     n;
        logic [7:0]     wmask;
        logic [7:0][6:0] a;
    } vec_t;

    typedef struct packed {
        logic [6:0] addr;
        logic       wrap;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[7];
    int   n_chk = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input logic mode, input int base, input int last, input int step,
                                input int n, input logic [7:0] wmask,
                                input int a0, input int a1, input int a2, input int a3, input int a4);
        vec_t v;
        v = '0;
        v.mode = mode; v.base = 7'(base); v.last = 7'(last); v.step = 4'(step);
        v.n = 4'(n); v.wmask = wmask;
        v.a[0] = 7'(a0); v.a[1] = 7'(a1); v.a[2] = 7'(a2); v.a[3] = 7'(a3); v.a[4] = 7'(a4);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int addr, input logic wrap);
        exp_t e;
        e.addr = 7'(addr);
        e.wrap = wrap;
        sb.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge where the first address is visible.
    task automatic start_seq(input logic mode, input int base, input int last, input int step);
        i_mode = mode; i_base_addr = 7'(base); i_last_addr = 7'(last); i_step = 4'(step);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_base_addr = 7'h55; i_last_addr = 7'h02; i_step = 4'd9; i_mode = ~mode;
        chk("busy_after_start", o_busy, 1);
    endtask

    // end_kind: 0 none, 1 expect done, 2 stop on the last item's cycle
    task automatic drain(input int n, input int end_kind);
        exp_t e;
        i_addr_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
                break;
            end
            e = sb.pop_front();
            chk("addr", o_read_addr, e.addr);
            chk("wrap_pulse", o_wrap_pulse, e.wrap);
            chk("valid_in_run", o_addr_valid, 1);
            chk("no_done_in_run", o_done, 0);
            if (k == n - 1 && end_kind == 2) i_stop = 1'b1;
            @(negedge clk);
        end
        i_stop = 1'b0;
        if (end_kind == 1) begin
            chk("done_pulse", o_done, 1);
            chk("valid_after_done", o_addr_valid, 0);
            chk("busy_after_done", o_busy, 0);
            chk("addr_after_done", o_read_addr, 0);
            chk("wrap_with_done", o_wrap_pulse, 0);
            @(negedge clk);
            chk("done_one_cycle", o_done, 0);
        end else if (end_kind == 2) begin
            chk("valid_after_stop", o_addr_valid, 0);
            chk("busy_after_stop", o_busy, 0);
            chk("addr_after_stop", o_read_addr, 0);
            chk("no_done_on_stop", o_done, 0);
            chk("no_wrap_on_stop", o_wrap_pulse, 0);
            @(negedge clk);
        end
    endtask

    initial begin
        vecs[0] = mk(1'b1,  10,  20, 4, 3, 8'b00000,  10,  14,  18,   0,   0);
        vecs[1] = mk(1'b0, 120, 127, 5, 5, 8'b10100, 120, 125, 120, 125, 120);
        vecs[2] = mk(1'b1,   3,   6, 0, 4, 8'b00000,   3,   4,   5,   6,   0);
        vecs[3] = mk(1'b1,  50,  40, 3, 1, 8'b00000,  50,   0,   0,   0,   0);
        vecs[4] = mk(1'b0,  50,  40, 2, 3, 8'b00110,  50,  50,  50,   0,   0);
        vecs[5] = mk(1'b1, 120, 127, 8, 1, 8'b00000, 120,   0,   0,   0,   0);
        vecs[6] = mk(1'b0,   0,   9, 3, 5, 8'b10000,   0,   3,   6,   9,   0);

        #1;
        chk("reset_addr", o_read_addr, 0);
        chk("reset_valid", o_addr_valid, 0);
        chk("reset_busy", o_busy, 0);
        chk("reset_done", o_done, 0);
        chk("reset_wrap", o_wrap_pulse, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            for (int k = 0; k < int'(vecs[v].n); k++) push(int'(vecs[v].a[k]), vecs[v].wmask[k]);
            start_seq(vecs[v].mode, int'(vecs[v].base), int'(vecs[v].last), int'(vecs[v].step));
            drain(int'(vecs[v].n), vecs[v].mode ? 1 : 2);
        end

        // full 7-bit wrap
        for (int a = 0; a < 128; a++) push(a, 1'b0);
        push(0, 1'b1);
        push(1, 1'b0);
        start_seq(1'b0, 0, 127, 1);
        drain(130, 2);

        // backpressure at 14, config inputs scrambled during RUN
        push(10, 1'b0);
        start_seq(1'b1, 10, 20, 4);
        drain(1, 0);
        i_addr_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("stall_addr", o_read_addr, 14);
            chk("stall_valid", o_addr_valid, 1);
            @(negedge clk);
        end
        push(14, 1'b0);
        push(18, 1'b0);
        drain(2, 1);

        // step 0 -> 1, stop at address 5 with ready high
        for (int a = 0; a < 6; a++) push(a, 1'b0);
        start_seq(1'b1, 0, 20, 0);
        drain(6, 2);

        // start together with stop in IDLE
        i_base_addr = 7'd7; i_last_addr = 7'd9; i_step = 4'd1;
        i_start = 1'b1; i_stop = 1'b1;
        @(negedge clk);
        i_start = 1'b0; i_stop = 1'b0;
        chk("startstop_valid", o_addr_valid, 0);
        chk("startstop_busy", o_busy, 0);
        @(negedge clk);
        chk("startstop_valid2", o_addr_valid, 0);

        // async reset mid-RUN
        start_seq(1'b0, 30, 100, 2);
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_addr", o_read_addr, 34);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_addr", o_read_addr, 0);
        chk("async_rst_valid", o_addr_valid, 0);
        chk("async_rst_busy", o_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", o_addr_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

endmodule
